// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory.
//   state_e   : loader FSM states
//   HDR_BYTES : length of the big-endian word-count header
//   NOP_WORD  : value driven on Instruction while busy or out of range
//   count_w() : width of load_count for a given ADDR_WIDTH
package imem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_DATA,
    ST_DONE
  } state_e;

  localparam int          HDR_BYTES = 2;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  // load_count must be able to hold the full depth, 2^aw.
  function automatic int count_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles a byte stream (MSB byte first) into words.
//   clk, reset   : clock, async active-low reset
//   clr_i        : synchronous clear, drops any partially built word
//   byte_valid_i : byte_i is consumed this cycle
//   byte_i       : stream byte
//   word_valid_o : combinational, high on the cycle the last byte is consumed
//   word_o       : assembled word, valid with word_valid_o
module imem_byte_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int DATA_WIDTH     = 8 * BYTES_PER_WORD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic                  word_valid_o,
  output logic [DATA_WIDTH-1:0] word_o
);

  localparam int CW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [CW-1:0] LAST = CW'(BYTES_PER_WORD - 1);

  logic [CW-1:0] cnt_q;

  assign word_valid_o = byte_valid_i && (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (byte_valid_i) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  generate
    if (BYTES_PER_WORD == 1) begin : g_single
      assign word_o = byte_i;
    end else begin : g_shift
      // Holds the BYTES_PER_WORD-1 earlier bytes; the incoming byte completes the word.
      logic [DATA_WIDTH-9:0] shift_q;
      logic [DATA_WIDTH-1:0] shift_d;

      assign shift_d = {shift_q, byte_i};
      assign word_o  = shift_d;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          shift_q <= '0;
        end else if (clr_i) begin
          shift_q <= '0;
        end else if (byte_valid_i) begin
          shift_q <= shift_d[DATA_WIDTH-9:0];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/imem_loader.sv
// Run-time loadable instruction memory for the single-cycle core.
// A session is a 2-byte big-endian word count N followed by N words (MSB
// byte first) written to word addresses 0..N-1. Words past the array depth
// are consumed and dropped so the stream stays aligned.
//   clk, reset    : clock, async active-low reset
//   Address       : byte address from the PC
//   Instruction   : combinational fetch data (NOP while busy / out of range)
//   addr_fault    : Address out of range or misaligned
//   load_start    : begin or restart a session
//   load_byte/valid/ready : byte stream handshake
//   load_busy     : session in progress (CPU hold)
//   load_done     : one-cycle pulse at session end
//   load_err      : header count exceeded depth (sticky until next start)
//   load_count    : words written this session, saturating at depth
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 9,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTES_PER_WORD = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [31:0]                    Address,
  output logic [DATA_WIDTH-1:0]          Instruction,
  output logic                           addr_fault,
  input  logic                           load_start,
  input  logic [7:0]                     load_byte,
  input  logic                           load_valid,
  output logic                           load_ready,
  output logic                           load_busy,
  output logic                           load_done,
  output logic                           load_err,
  output logic [count_w(ADDR_WIDTH)-1:0] load_count
);

  localparam int          CNT_W = count_w(ADDR_WIDTH);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [CNT_W-1:0]  wcnt_q;   // words actually written
  logic [15:0]       wtot_q;   // words received, including discarded ones
  logic [15:0]       n_q;

  logic                  accept;
  logic                  pk_valid;
  logic                  word_valid;
  logic [DATA_WIDTH-1:0] word;
  logic                  wr_en;
  logic [15:0]           hdr_n;
  logic [15:0]           wtot_inc;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // ready and busy cover the same states (HDR_HI, HDR_LO, DATA).
  assign accept   = load_valid && busy_q;
  assign pk_valid = accept && (state_q == ST_DATA);
  assign wr_en    = word_valid && ({16'd0, wtot_q} < DEPTH);
  assign hdr_n    = {n_q[15:8], load_byte};
  assign wtot_inc = wtot_q + 16'd1;

  imem_byte_packer #(
    .BYTES_PER_WORD(BYTES_PER_WORD),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_packer (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (load_start),
    .byte_valid_i(pk_valid),
    .byte_i      (load_byte),
    .word_valid_o(word_valid),
    .word_o      (word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
      wtot_q  <= '0;
      n_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (wr_en && (wcnt_q != CNT_W'(DEPTH))) wcnt_q <= wcnt_q + CNT_W'(1);
      if (pk_valid && word_valid) wtot_q <= wtot_inc;

      // Start overrides everything below, including a final-byte done.
      // The write on that edge still happens via wr_en.
      if (load_start) begin
        state_q <= ST_HDR_HI;
        busy_q  <= 1'b1;
        err_q   <= 1'b0;
        wcnt_q  <= '0;
        wtot_q  <= '0;
      end else begin
        case (state_q)
          ST_HDR_HI: begin
            if (accept) begin
              n_q[15:8] <= load_byte;
              state_q   <= ST_HDR_LO;
            end
          end
          ST_HDR_LO: begin
            if (accept) begin
              n_q[7:0] <= load_byte;
              wtot_q   <= '0;
              if (32'(hdr_n) > DEPTH) err_q <= 1'b1;
              if (hdr_n == 16'd0) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (word_valid && (wtot_inc == n_q)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wtot_q[ADDR_WIDTH-1:0]] <= word;
  end

  // Combinational read path.
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  hi_bad;

  assign rd_idx      = Address[ADDR_WIDTH+1:2];
  assign hi_bad      = |Address[31:ADDR_WIDTH+2];
  assign addr_fault  = hi_bad || (|Address[1:0]);
  assign Instruction = (busy_q || hi_bad) ? DATA_WIDTH'(NOP_WORD) : mem_q[rd_idx];

  assign load_ready = busy_q;
  assign load_busy  = busy_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign load_count = wcnt_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = '0;

  logic [31:0] instr9, instr2;
  logic        fault9, fault2, ready9, ready2, busy9, busy2;
  logic        done9, done2, err9, err2;
  logic [9:0]  cnt9;
  logic [2:0]  cnt2;

  int npass = 0;
  int ntotal = 0;
  int done9_n = 0;
  int done2_n = 0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(9)) dut9 (
    .clk(clk), .reset(rst_n), .Address(addr), .Instruction(instr9),
    .addr_fault(fault9), .load_start(ld_start), .load_byte(ld_byte),
    .load_valid(ld_valid), .load_ready(ready9), .load_busy(busy9),
    .load_done(done9), .load_err(err9), .load_count(cnt9)
  );

  imem_loader #(.ADDR_WIDTH(2)) dut2 (
    .clk(clk), .reset(rst_n), .Address(addr), .Instruction(instr2),
    .addr_fault(fault2), .load_start(ld_start), .load_byte(ld_byte),
    .load_valid(ld_valid), .load_ready(ready2), .load_busy(busy2),
    .load_done(done2), .load_err(err2), .load_count(cnt2)
  );

  always @(posedge clk) begin
    if (done9) done9_n++;
    if (done2) done2_n++;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] i9;
    logic        f9;
    logic [31:0] i2;
    logic        f2;
  } rd_vec_t;

  rd_vec_t rv[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_s();
    ld_start = 1'b1;
    @(posedge clk); #1;
    ld_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    ld_byte  = b;
    ld_valid = 1'b1;
    for (int i = 0; i < 50 && !ready9; i++) begin
      @(posedge clk); #1;
    end
    if (!ready9) chk("send_ready_timeout", {31'd0, ready9}, 32'd1);
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send(w[31:24]); send(w[23:16]); send(w[15:8]); send(w[7:0]);
  endtask

  task automatic rd(input logic [31:0] a);
    addr = a;
    #1;
  endtask

  initial begin
    rv[0] = '{32'h0000_0000, 32'h2010_0000, 1'b0, 32'h2010_0000, 1'b0};
    rv[1] = '{32'h0000_0004, 32'h2012_0000, 1'b0, 32'h2012_0000, 1'b0};
    rv[2] = '{32'h0000_0006, 32'h2012_0000, 1'b1, 32'h2012_0000, 1'b1};
    rv[3] = '{32'h0000_0002, 32'h2010_0000, 1'b1, 32'h2010_0000, 1'b1};
    rv[4] = '{32'h0000_0800, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    rv[5] = '{32'h8000_0004, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};

    // Reset state
    #12;
    chk("rst_ready", {31'd0, ready9}, 0);
    chk("rst_busy",  {31'd0, busy9},  0);
    chk("rst_done",  {31'd0, done9},  0);
    chk("rst_err",   {31'd0, err9},   0);
    chk("rst_count", {22'd0, cnt9},   0);
    rst_n = 1'b1;
    cyc(1);

    // Basic 2-word session with a gap in the stream
    start_s();
    chk("s1_busy_after_start", {31'd0, busy9}, 1);
    chk("s1_ready", {31'd0, ready9}, 1);
    send(8'h00); send(8'h02);
    send(8'h20); send(8'h10);
    cyc(3);
    send(8'h00); send(8'h00);
    send_word(32'h2012_0000);
    chk("s1_done_pulse", {31'd0, done9}, 1);
    chk("s1_busy_fall",  {31'd0, busy9}, 0);
    chk("s1_count",      {22'd0, cnt9},  2);
    cyc(1);
    chk("s1_done_low", {31'd0, done9}, 0);
    chk("s1_done_n", done9_n, 1);
    for (int k = 0; k < 6; k++) begin
      rd(rv[k].a);
      chk($sformatf("rd%0d_instr9", k), instr9, rv[k].i9);
      chk($sformatf("rd%0d_fault9", k), {31'd0, fault9}, {31'd0, rv[k].f9});
      chk($sformatf("rd%0d_instr2", k), instr2, rv[k].i2);
      chk($sformatf("rd%0d_fault2", k), {31'd0, fault2}, {31'd0, rv[k].f2});
    end

    // Zero-length session
    start_s();
    send(8'h00); send(8'h00);
    chk("s0_done", {31'd0, done9}, 1);
    chk("s0_busy", {31'd0, busy9}, 0);
    chk("s0_count", {22'd0, cnt9}, 0);
    cyc(1);
    rd(32'h0);
    chk("s0_word0_kept", instr9, 32'h2010_0000);
    chk("s0_done_n", done9_n, 2);

    // Oversize header: dut2 has depth 4, N=6
    start_s();
    rd(32'h0);
    chk("ov_nop_busy", instr9, 32'h0);
    send(8'h00); send(8'h06);
    chk("ov_err2", {31'd0, err2}, 1);
    chk("ov_err9", {31'd0, err9}, 0);
    for (int k = 0; k < 6; k++) begin
      send_word(32'h0A00_0000 + k);
      if (k == 3) begin
        chk("ov_cnt2_mid", {29'd0, cnt2}, 4);
        chk("ov_busy2_mid", {31'd0, busy2}, 1);
      end
    end
    chk("ov_done2", {31'd0, done2}, 1);
    chk("ov_cnt2_sat", {29'd0, cnt2}, 4);
    chk("ov_cnt9", {22'd0, cnt9}, 6);
    cyc(1);
    chk("ov_done2_n", done2_n, 3);
    chk("ov_err2_sticky", {31'd0, err2}, 1);
    for (int k = 0; k < 4; k++) begin
      rd(32'(k * 4));
      chk($sformatf("ov_rd2_%0d", k), instr2, 32'h0A00_0000 + k);
    end
    rd(32'h14);
    chk("ov_rd9_5", instr9, 32'h0A00_0005);

    // Abort mid-word, then a clean 1-word session
    start_s();
    chk("ab_err2_clr", {31'd0, err2}, 0);
    send(8'h00); send(8'h01); send(8'h12); send(8'h34);
    start_s();
    chk("ab_cnt_clr", {22'd0, cnt9}, 0);
    chk("ab_busy", {31'd0, busy9}, 1);
    send(8'h00); send(8'h01);
    send_word(32'hAC88_0000);
    cyc(1);
    rd(32'h0);
    chk("ab_word0_9", instr9, 32'hAC88_0000);
    chk("ab_word0_2", instr2, 32'hAC88_0000);
    rd(32'h4);
    chk("ab_word1_9", instr9, 32'h0A00_0001);
    chk("ab_done_n", done9_n, 4);

    // Start with valid in IDLE: byte not consumed
    ld_byte = 8'hFF; ld_valid = 1'b1; ld_start = 1'b1;
    @(posedge clk); #1;
    ld_start = 1'b0; ld_valid = 1'b0;
    chk("sv_busy", {31'd0, busy9}, 1);
    send(8'h00); send(8'h01);
    send_word(32'hDEAD_BEEF);
    chk("sv_done", {31'd0, done9}, 1);
    cyc(1);
    rd(32'h0);
    chk("sv_word0", instr9, 32'hDEAD_BEEF);

    // Start coincident with final byte accept: written, restarted, no done
    start_s();
    send(8'h00); send(8'h01);
    send(8'h01); send(8'h02); send(8'h03);
    ld_byte = 8'h04; ld_valid = 1'b1; ld_start = 1'b1;
    @(posedge clk); #1;
    ld_start = 1'b0; ld_valid = 1'b0;
    chk("fs_busy", {31'd0, busy9}, 1);
    chk("fs_no_done", {31'd0, done9}, 0);
    chk("fs_cnt", {22'd0, cnt9}, 0);

    // Reset mid-DATA with valid held high
    send(8'h00); send(8'h02);
    send(8'hAA); send(8'hBB);
    ld_byte = 8'hCC; ld_valid = 1'b1;
    #3; rst_n = 1'b0; #1;
    chk("rr_busy", {31'd0, busy9}, 0);
    chk("rr_ready", {31'd0, ready9}, 0);
    @(posedge clk); #1;
    ld_valid = 1'b0; rst_n = 1'b1;
    cyc(1);
    chk("rr_cnt", {22'd0, cnt9}, 0);
    rd(32'h0);
    chk("rr_word0_9", instr9, 32'h0102_0304);
    chk("rr_word0_2", instr2, 32'h0102_0304);
    rd(32'h4);
    chk("rr_word1_9", instr9, 32'h0A00_0001);
    chk("rr_done_n9", done9_n, 5);
    chk("rr_done_n2", done2_n, 5);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
